instr_queue_mw: RTL and testbench



---
 rtl/instr_queue_mw_if.sv | 47 ++++
 rtl/instr_queue_mw.sv | 219 +++++++++++++++++++++
 tb/tb_instr_queue_mw.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/instr_queue_mw_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// instr_queue_mw_if : fetch/decode-side bundle of the multi-width instr queue
// Rev 1.0
// ----------------------------------------------------------------------------
interface instr_queue_mw_if #(
  parameter int DEPTH   = 16,
  parameter int FETCH_W = 2,
  parameter int ISSUE_W = 2,
  parameter int EXP_W   = 3
);
  localparam int CW   = $clog2(DEPTH) + 1;
  localparam int RC_W = $clog2(ISSUE_W + 1);

  logic                       flush;
  logic                       flush_keep_slot;
  logic                       branch_last;
  logic [FETCH_W-1:0]         write_en;
  logic [32*FETCH_W-1:0]      write_data;
  logic [32*FETCH_W-1:0]      write_addr;
  logic [EXP_W*FETCH_W-1:0]   write_exp;
  logic [RC_W-1:0]            read_count;
  logic [ISSUE_W-1:0]         out_valid;
  logic [32*ISSUE_W-1:0]      out_data;
  logic [32*ISSUE_W-1:0]      out_addr;
  logic [EXP_W*ISSUE_W-1:0]   out_exp;
  logic                       out_delay_slot;
  logic [CW-1:0]              count;
  logic                       empty;
  logic                       full;
  logic [63:0]                retired;

  modport master (
    output flush, flush_keep_slot, branch_last, write_en, write_data,
           write_addr, write_exp, read_count,
    input  out_valid, out_data, out_addr, out_exp, out_delay_slot,
           count, empty, full, retired
  );

  modport slave (
    input  flush, flush_keep_slot, branch_last, write_en, write_data,
           write_addr, write_exp, read_count,
    output out_valid, out_data, out_addr, out_exp, out_delay_slot,
           count, empty, full, retired
  );
endinterface
`default_nettype wire

// File: rtl/instr_queue_mw.sv
`default_nettype none
// ----------------------------------------------------------------------------
// instr_queue_mw : multi-width fetch->decode instruction queue with delay-slot
//                  capture on branch flush and a retired-instruction counter
// Rev 1.0
// ----------------------------------------------------------------------------
module instr_queue_mw #(
  parameter int DEPTH   = 16,
  parameter int FETCH_W = 2,
  parameter int ISSUE_W = 2,
  parameter int EXP_W   = 3
) (
  input  logic             clk,
  input  logic             rst,
  instr_queue_mw_if.slave  bus
);
  localparam int PW   = $clog2(DEPTH);
  localparam int CW   = PW + 1;
  localparam int RC_W = $clog2(ISSUE_W + 1);
  localparam int NW_W = $clog2(FETCH_W + 1);

  typedef enum logic [1:0] {
    ST_NORMAL    = 2'd0,
    ST_SLOT_WAIT = 2'd1,
    ST_SLOT_HELD = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [31:0]        mem_data_q [DEPTH];
  logic [31:0]        mem_addr_q [DEPTH];
  logic [EXP_W-1:0]   mem_exp_q  [DEPTH];
  logic [PW-1:0]      rp_q, rp_d, wp_q, wp_d;
  logic [CW-1:0]      count_q, count_d;
  logic               flag_q, flag_d;
  logic [63:0]        retired_q, retired_d;
  logic [31:0]        slot_data_q, slot_addr_q;
  logic [EXP_W-1:0]   slot_exp_q;
  logic               slot_we, slot_from_write;

  logic [NW_W-1:0]    w_nw, w_nq;
  logic [FETCH_W:0]   w_we_ext;
  logic               w_thermo, w_full, w_accept, w_shift;
  logic [RC_W-1:0]    w_nvalid, w_nr;
  logic [PW-1:0]      w_rp1;
  logic [PW-1:0]      w_rd_idx [ISSUE_W];
  logic [PW-1:0]      w_wr_idx [FETCH_W];
  logic [FETCH_W-1:0] w_lane_we;
  logic [31:0]        w_slot_data, w_slot_addr;
  logic [EXP_W-1:0]   w_slot_exp;

  always_comb begin
    w_nw = '0;
    for (int i = 0; i < FETCH_W; i++) w_nw = w_nw + NW_W'(bus.write_en[i]);
  end

  // x & (x+1) == 0 holds exactly for 0..01..1 patterns
  assign w_we_ext = {1'b0, bus.write_en};
  assign w_thermo = ((w_we_ext + {{FETCH_W{1'b0}}, 1'b1}) & w_we_ext) == '0;
  assign w_full   = (CW'(DEPTH) - count_q) < CW'(FETCH_W);
  assign w_accept = w_thermo & ~w_full & ~bus.flush;
  assign w_shift  = (state_q == ST_SLOT_WAIT) & w_accept & bus.write_en[0];
  assign w_nq     = w_accept ? (w_nw - NW_W'(w_shift)) : '0;
  assign w_rp1    = rp_q + PW'(1);

  always_comb begin
    w_nvalid = '0;
    case (state_q)
      ST_NORMAL:    w_nvalid = (count_q >= CW'(ISSUE_W)) ? RC_W'(ISSUE_W) : RC_W'(count_q);
      ST_SLOT_HELD: w_nvalid = RC_W'(1);
      default:      w_nvalid = '0;
    endcase
  end

  assign w_nr = (bus.read_count < w_nvalid) ? bus.read_count : w_nvalid;

  generate
    for (genvar g = 0; g < ISSUE_W; g++) begin : g_rd_idx
      assign w_rd_idx[g] = rp_q + PW'(g);
    end
    for (genvar g = 0; g < FETCH_W; g++) begin : g_wr_lane
      assign w_wr_idx[g]  = wp_q + PW'(g) - PW'(w_shift);
      // In SLOT_WAIT lane 0 goes to the slot register, not the queue
      assign w_lane_we[g] = (g == 0) ? (w_accept & bus.write_en[g] & ~w_shift)
                                     : (w_accept & bus.write_en[g]);
    end
  endgenerate

  always_ff @(posedge clk) begin
    for (int i = 0; i < FETCH_W; i++) begin
      if (w_lane_we[i]) begin
        mem_data_q[w_wr_idx[i]] <= bus.write_data[i*32 +: 32];
        mem_addr_q[w_wr_idx[i]] <= bus.write_addr[i*32 +: 32];
        mem_exp_q[w_wr_idx[i]]  <= bus.write_exp[i*EXP_W +: EXP_W];
      end
    end
  end

  assign w_slot_data = slot_from_write ? bus.write_data[31:0]   : mem_data_q[w_rp1];
  assign w_slot_addr = slot_from_write ? bus.write_addr[31:0]   : mem_addr_q[w_rp1];
  assign w_slot_exp  = slot_from_write ? bus.write_exp[EXP_W-1:0] : mem_exp_q[w_rp1];

  always_comb begin
    state_d         = state_q;
    rp_d            = rp_q;
    wp_d            = wp_q;
    count_d         = count_q;
    flag_d          = flag_q;
    retired_d       = retired_q;
    slot_we         = 1'b0;
    slot_from_write = 1'b0;
    if (bus.flush) begin
      rp_d    = '0;
      wp_d    = '0;
      count_d = '0;
      flag_d  = 1'b0;
      if (!bus.flush_keep_slot) begin
        state_d = ST_NORMAL;
      end else if (count_q >= CW'(2)) begin
        slot_we = 1'b1;
        state_d = ST_SLOT_HELD;
      end else if (bus.write_en[0]) begin
        slot_we         = 1'b1;
        slot_from_write = 1'b1;
        state_d         = ST_SLOT_HELD;
      end else begin
        state_d = ST_SLOT_WAIT;
      end
    end else begin
      wp_d = wp_q + PW'(w_nq);
      case (state_q)
        ST_NORMAL: begin
          rp_d      = rp_q + PW'(w_nr);
          count_d   = count_q + CW'(w_nq) - CW'(w_nr);
          retired_d = retired_q + 64'(w_nr);
          if (w_nr != '0) flag_d = bus.branch_last;
        end
        ST_SLOT_WAIT: begin
          count_d = count_q + CW'(w_nq);
          if (w_shift) begin
            slot_we         = 1'b1;
            slot_from_write = 1'b1;
            state_d         = ST_SLOT_HELD;
          end
        end
        ST_SLOT_HELD: begin
          count_d = count_q + CW'(w_nq);
          if (w_nr != '0) begin
            retired_d = retired_q + 64'(w_nr);
            flag_d    = bus.branch_last;
            state_d   = ST_NORMAL;
          end
        end
        default: state_d = ST_NORMAL;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_NORMAL;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rp_q        <= '0;
      wp_q        <= '0;
      count_q     <= '0;
      flag_q      <= 1'b0;
      retired_q   <= '0;
      slot_data_q <= '0;
      slot_addr_q <= '0;
      slot_exp_q  <= '0;
    end else begin
      rp_q      <= rp_d;
      wp_q      <= wp_d;
      count_q   <= count_d;
      flag_q    <= flag_d;
      retired_q <= retired_d;
      if (slot_we) begin
        slot_data_q <= w_slot_data;
        slot_addr_q <= w_slot_addr;
        slot_exp_q  <= w_slot_exp;
      end
    end
  end

  always_comb begin
    bus.out_valid = '0;
    bus.out_data  = '0;
    bus.out_addr  = '0;
    bus.out_exp   = '0;
    case (state_q)
      ST_NORMAL: begin
        for (int i = 0; i < ISSUE_W; i++) begin
          if (CW'(i) < count_q) begin
            bus.out_valid[i]                 = 1'b1;
            bus.out_data[i*32 +: 32]         = mem_data_q[w_rd_idx[i]];
            bus.out_addr[i*32 +: 32]         = mem_addr_q[w_rd_idx[i]];
            bus.out_exp[i*EXP_W +: EXP_W]    = mem_exp_q[w_rd_idx[i]];
          end
        end
      end
      ST_SLOT_HELD: begin
        bus.out_valid[0]          = 1'b1;
        bus.out_data[31:0]        = slot_data_q;
        bus.out_addr[31:0]        = slot_addr_q;
        bus.out_exp[EXP_W-1:0]    = slot_exp_q;
      end
      default: ;
    endcase
  end

  assign bus.out_delay_slot = (state_q == ST_SLOT_HELD) | ((state_q == ST_NORMAL) & flag_q);
  assign bus.count          = count_q;
  assign bus.empty          = (count_q == '0);
  assign bus.full           = w_full;
  assign bus.retired        = retired_q;
endmodule
`default_nettype wire

// File: tb/tb_instr_queue_mw.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_instr_queue_mw : directed vector table plus fill, stream and reset checks
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_instr_queue_mw;
  localparam int DEPTH   = 16;
  localparam int FETCH_W = 2;
  localparam int ISSUE_W = 2;
  localparam int EXP_W   = 3;
  localparam logic [31:0] DKEY = 32'hA5A5_0000;
  localparam int NV = 17;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [63:0] exp_ret = '0;

  instr_queue_mw_if #(.DEPTH(DEPTH), .FETCH_W(FETCH_W), .ISSUE_W(ISSUE_W), .EXP_W(EXP_W)) bus ();

  instr_queue_mw #(.DEPTH(DEPTH), .FETCH_W(FETCH_W), .ISSUE_W(ISSUE_W), .EXP_W(EXP_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        fl;
    logic        keep;
    logic        br;
    logic [1:0]  we;
    logic [31:0] pc;
    logic [1:0]  rc;
    logic [1:0]  e_valid;
    logic [31:0] e_a0;
    logic [31:0] e_a1;
    logic [4:0]  e_cnt;
    logic        e_ds;
    logic [63:0] e_ret;
  } vec_t;

  vec_t vec [NV];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic fl, input logic keep, input logic br,
                       input logic [1:0] we, input logic [31:0] pc, input logic [1:0] rc);
    logic [31:0] pc1;
    pc1 = pc + 32'd4;
    bus.flush           = fl;
    bus.flush_keep_slot = keep;
    bus.branch_last     = br;
    bus.write_en        = we;
    bus.write_addr      = {pc1, pc};
    bus.write_data      = {pc1 ^ DKEY, pc ^ DKEY};
    bus.write_exp       = {pc1[4:2], pc[4:2]};
    bus.read_count      = rc;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic check_lanes(input string tag, input logic [1:0] ev,
                             input logic [31:0] a0, input logic [31:0] a1);
    logic [31:0] ea [2];
    logic [31:0] a;
    ea[0] = a0;
    ea[1] = a1;
    check({tag, ".valid"}, 64'(bus.out_valid), 64'(ev));
    for (int i = 0; i < 2; i++) begin
      a = ea[i];
      check($sformatf("%s.addr%0d", tag, i), 64'(bus.out_addr[i*32 +: 32]), ev[i] ? 64'(a) : 64'd0);
      check($sformatf("%s.data%0d", tag, i), 64'(bus.out_data[i*32 +: 32]), ev[i] ? 64'(a ^ DKEY) : 64'd0);
      check($sformatf("%s.exp%0d", tag, i), 64'(bus.out_exp[i*EXP_W +: EXP_W]), ev[i] ? 64'(a[4:2]) : 64'd0);
    end
  endtask

  initial begin
    logic [31:0] mq [$];
    logic [31:0] pc;
    logic [1:0]  we;
    logic [1:0]  rc;
    logic [1:0]  ev;
    int pushed, popped, nv, nr, r;
    logic full_m;

    //             fl keep br  we     pc        rc   valid  a0        a1        cnt  ds   ret
    vec[0]  = '{1'b0,1'b0,1'b0,2'b11,32'h100,2'd0,2'b11,32'h100,32'h104,5'd2,1'b0,64'd0};
    vec[1]  = '{1'b0,1'b0,1'b0,2'b11,32'h108,2'd0,2'b11,32'h100,32'h104,5'd4,1'b0,64'd0};
    vec[2]  = '{1'b0,1'b0,1'b0,2'b00,32'h000,2'd2,2'b11,32'h108,32'h10C,5'd2,1'b0,64'd2};
    vec[3]  = '{1'b0,1'b0,1'b1,2'b01,32'h110,2'd1,2'b11,32'h10C,32'h110,5'd2,1'b1,64'd3};
    vec[4]  = '{1'b0,1'b0,1'b0,2'b00,32'h000,2'd1,2'b01,32'h110,32'h000,5'd1,1'b0,64'd4};
    vec[5]  = '{1'b0,1'b0,1'b0,2'b00,32'h000,2'd2,2'b00,32'h000,32'h000,5'd0,1'b0,64'd5};
    vec[6]  = '{1'b0,1'b0,1'b0,2'b10,32'h500,2'd0,2'b00,32'h000,32'h000,5'd0,1'b0,64'd5};
    vec[7]  = '{1'b0,1'b0,1'b0,2'b11,32'h200,2'd0,2'b11,32'h200,32'h204,5'd2,1'b0,64'd5};
    vec[8]  = '{1'b0,1'b0,1'b0,2'b01,32'h208,2'd0,2'b11,32'h200,32'h204,5'd3,1'b0,64'd5};
    vec[9]  = '{1'b1,1'b1,1'b0,2'b11,32'h600,2'd1,2'b01,32'h204,32'h000,5'd0,1'b1,64'd5};
    vec[10] = '{1'b0,1'b0,1'b0,2'b00,32'h000,2'd1,2'b00,32'h000,32'h000,5'd0,1'b0,64'd6};
    vec[11] = '{1'b1,1'b1,1'b0,2'b00,32'h000,2'd0,2'b00,32'h000,32'h000,5'd0,1'b0,64'd6};
    vec[12] = '{1'b0,1'b0,1'b0,2'b11,32'h300,2'd0,2'b01,32'h300,32'h000,5'd1,1'b1,64'd6};
    vec[13] = '{1'b0,1'b0,1'b1,2'b00,32'h000,2'd1,2'b01,32'h304,32'h000,5'd1,1'b1,64'd7};
    vec[14] = '{1'b0,1'b0,1'b0,2'b00,32'h000,2'd1,2'b00,32'h000,32'h000,5'd0,1'b0,64'd8};
    vec[15] = '{1'b1,1'b1,1'b0,2'b11,32'h700,2'd0,2'b01,32'h700,32'h000,5'd0,1'b1,64'd8};
    vec[16] = '{1'b1,1'b0,1'b0,2'b00,32'h000,2'd0,2'b00,32'h000,32'h000,5'd0,1'b0,64'd8};

    drive(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 2'd0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst.count", 64'(bus.count), 64'd0);
    check("rst.empty", 64'(bus.empty), 64'd1);
    check("rst.full", 64'(bus.full), 64'd0);
    check("rst.retired", bus.retired, 64'd0);
    check("rst.ds", 64'(bus.out_delay_slot), 64'd0);
    check_lanes("rst", 2'b00, 32'h0, 32'h0);
    #2 rst = 1'b0;
    step();

    for (int i = 0; i < NV; i++) begin
      drive(vec[i].fl, vec[i].keep, vec[i].br, vec[i].we, vec[i].pc, vec[i].rc);
      step();
      check($sformatf("v%0d.count", i), 64'(bus.count), 64'(vec[i].e_cnt));
      check($sformatf("v%0d.empty", i), 64'(bus.empty), 64'(vec[i].e_cnt == 5'd0));
      check($sformatf("v%0d.full", i), 64'(bus.full), 64'd0);
      check($sformatf("v%0d.ds", i), 64'(bus.out_delay_slot), 64'(vec[i].e_ds));
      check($sformatf("v%0d.retired", i), bus.retired, vec[i].e_ret);
      check_lanes($sformatf("v%0d", i), vec[i].e_valid, vec[i].e_a0, vec[i].e_a1);
    end
    exp_ret = vec[NV-1].e_ret;

    // fill to 15 entries, then a dropped bundle, then a read of two
    for (int b = 0; b < 7; b++) begin
      drive(1'b0, 1'b0, 1'b0, 2'b11, 32'h2000 + 32'(b * 8), 2'd0);
      step();
    end
    check("fill14.count", 64'(bus.count), 64'd14);
    check("fill14.full", 64'(bus.full), 64'd0);
    drive(1'b0, 1'b0, 1'b0, 2'b01, 32'h2038, 2'd0);
    step();
    check("fill15.count", 64'(bus.count), 64'd15);
    check("fill15.full", 64'(bus.full), 64'd1);
    drive(1'b0, 1'b0, 1'b0, 2'b11, 32'h3000, 2'd0);
    step();
    check("drop.count", 64'(bus.count), 64'd15);
    drive(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 2'd2);
    step();
    check("rd2.count", 64'(bus.count), 64'd13);
    check("rd2.full", 64'(bus.full), 64'd0);
    check_lanes("rd2", 2'b11, 32'h2008, 32'h200C);
    for (int k = 0; k < 7; k++) step();
    check("drain.empty", 64'(bus.empty), 64'd1);
    check("drain.lastpc", 64'(bus.out_addr[31:0]), 64'd0);
    exp_ret = exp_ret + 64'd15;
    check("drain.retired", bus.retired, exp_ret);

    // random stream checked against a queue model
    pushed = 0;
    popped = 0;
    pc = 32'h4000;
    for (int cyc = 0; cyc < 400 && popped < 40; cyc++) begin
      we = 2'b00;
      if (pushed < 40) begin
        r = int'($urandom_range(0, 2));
        we = (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : 2'b11;
        if (pushed == 39 && we == 2'b11) we = 2'b01;
      end
      rc = 2'($urandom_range(0, 2));
      drive(1'b0, 1'b0, 1'b0, we, pc, rc);
      full_m = (DEPTH - mq.size()) < FETCH_W;
      nv = (mq.size() < 2) ? mq.size() : 2;
      nr = (int'(rc) < nv) ? int'(rc) : nv;
      for (int k = 0; k < nr; k++) void'(mq.pop_front());
      popped += nr;
      exp_ret = exp_ret + 64'(nr);
      if (!full_m) begin
        for (int k = 0; k < 2; k++) begin
          if (we[k]) begin
            mq.push_back(pc + 32'(4 * k));
            pushed++;
          end
        end
        pc = pc + ((we == 2'b11) ? 32'd8 : (we == 2'b01) ? 32'd4 : 32'd0);
      end
      step();
      ev = {mq.size() >= 2, mq.size() >= 1};
      check($sformatf("s%0d.count", cyc), 64'(bus.count), 64'(mq.size()));
      check_lanes($sformatf("s%0d", cyc), ev,
                  (mq.size() >= 1) ? mq[0] : 32'h0, (mq.size() >= 2) ? mq[1] : 32'h0);
    end
    if (popped < 40) begin
      checks++;
      errors++;
      $display("FAIL stream.timeout: consumed %0d required 40", popped);
    end
    check("stream.retired", bus.retired, exp_ret);
    check("stream.empty", 64'(bus.empty), 64'd1);

    // asynchronous reset mid-cycle with a non-empty queue
    drive(1'b0, 1'b0, 1'b0, 2'b11, 32'h5000, 2'd0);
    step();
    drive(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 2'd0);
    #2 rst = 1'b1;
    #1;
    check("arst.count", 64'(bus.count), 64'd0);
    check("arst.retired", bus.retired, 64'd0);
    check("arst.empty", 64'(bus.empty), 64'd1);
    check_lanes("arst", 2'b00, 32'h0, 32'h0);
    #2 rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
